// File: rtl/warp_table_fifo.sv
// warp_table_fifo: warp-entry FIFO between spawner and scheduler with occupancy,
// write-through when full, synchronous flush and sticky overflow/underflow flags.
module warp_table_fifo #(
    parameter int WIDTH      = 44,
    parameter int DEPTH      = 8,
    parameter int VACANT_MIN = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         read_en,
    input  logic                         write_en,
    input  logic [WIDTH-1:0]             write_data,
    output logic [WIDTH-1:0]             read_data,
    output logic                         read_valid,
    output logic                         fifo_empty,
    output logic                         fifo_full,
    output logic                         fifo_vacant,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow,
    output logic                         underflow,
    input  logic                         err_clr
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [CW-1:0] VMIN = CW'(VACANT_MIN);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic             do_pop, do_push, ovf_set, unf_set;

    assign fifo_empty  = count == '0;
    assign fifo_full   = count == FULL;
    assign fifo_vacant = (FULL - count) >= VMIN;

    // A pop frees the slot the concurrent push needs, so a full FIFO still accepts it.
    assign do_pop  = !flush && read_en && !fifo_empty;
    assign do_push = !flush && write_en && (!fifo_full || do_pop);
    assign ovf_set = !flush && write_en && fifo_full && !read_en;
    assign unf_set = !flush && read_en && fifo_empty;

    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= write_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            read_data  <= '0;
            read_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            read_valid <= do_pop;
            if (do_pop) read_data <= mem[rd_ptr];
            rd_ptr    <= flush ? '0 : do_pop  ? rd_ptr + 1'b1 : rd_ptr;
            wr_ptr    <= flush ? '0 : do_push ? wr_ptr + 1'b1 : wr_ptr;
            count     <= flush ? '0 :
                         (do_push && !do_pop) ? count + 1'b1 :
                         (do_pop && !do_push) ? count - 1'b1 : count;
            overflow  <= ovf_set | (overflow & ~err_clr);
            underflow <= unf_set | (underflow & ~err_clr);
        end
    end
endmodule

// File: tb/tb_warp_table_fifo.sv
// tb_warp_table_fifo: directed checks of warp_table_fifo with DEPTH=4, VACANT_MIN=2, WIDTH=8.
module tb_warp_table_fifo;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0, read_en = 1'b0, write_en = 1'b0, err_clr = 1'b0;
    logic [7:0] write_data = '0;
    logic [7:0] read_data;
    logic       read_valid, fifo_empty, fifo_full, fifo_vacant, overflow, underflow;
    logic [2:0] count;
    int         passed = 0;
    int         total = 0;

    warp_table_fifo #(.WIDTH(8), .DEPTH(4), .VACANT_MIN(2)) dut (
        .clk(clk), .rst(rst), .flush(flush), .read_en(read_en), .write_en(write_en),
        .write_data(write_data), .read_data(read_data), .read_valid(read_valid),
        .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_vacant(fifo_vacant),
        .count(count), .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push(input logic [7:0] d);
        write_en = 1'b1;
        write_data = d;
        step();
        write_en = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] d);
        read_en = 1'b1;
        step();
        read_en = 1'b0;
        chk({tag, "_valid"}, read_valid, 1);
        chk({tag, "_data"}, read_data, d);
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
    endtask

    initial begin
        step();
        step();
        chk("rst_empty", fifo_empty, 1);
        chk("rst_full", fifo_full, 0);
        chk("rst_vacant", fifo_vacant, 1);
        chk("rst_count", count, 0);
        chk("rst_valid", read_valid, 0);
        chk("rst_data", read_data, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_unf", underflow, 0);
        rst = 1'b0;
        step();
        read_en = 1'b1;
        step();
        read_en = 1'b0;
        chk("idle_valid", read_valid, 0);
        chk("idle_unf", underflow, 1);
        chk("idle_empty", fifo_empty, 1);
        chk("idle_count", count, 0);
        clear_err();
        chk("clr_unf", underflow, 0);
        chk("clr_ovf", overflow, 0);

        push(8'hA1);
        push(8'hB2);
        push(8'hC3);
        chk("ord_count", count, 3);
        pop_chk("ord_a1", 8'hA1);
        pop_chk("ord_b2", 8'hB2);
        pop_chk("ord_c3", 8'hC3);
        read_en = 1'b1;
        step();
        read_en = 1'b0;
        chk("ord_4th_valid", read_valid, 0);
        chk("ord_4th_unf", underflow, 1);
        chk("ord_4th_hold", read_data, 8'hC3);
        clear_err();

        push(8'h11);
        push(8'h22);
        chk("full_vac2", fifo_vacant, 1);
        push(8'h33);
        chk("full_vac3", fifo_vacant, 0);
        chk("full_notfull3", fifo_full, 0);
        push(8'h44);
        chk("full_full", fifo_full, 1);
        chk("full_ovf0", overflow, 0);
        push(8'hEE);
        chk("full_ovf", overflow, 1);
        chk("full_count", count, 4);
        pop_chk("drain_11", 8'h11);
        pop_chk("drain_22", 8'h22);
        pop_chk("drain_33", 8'h33);
        pop_chk("drain_44", 8'h44);
        chk("drain_empty", fifo_empty, 1);
        chk("drain_ovf_sticky", overflow, 1);
        clear_err();

        push(8'h01);
        push(8'h02);
        push(8'h03);
        push(8'h04);
        write_en = 1'b1;
        write_data = 8'h55;
        read_en = 1'b1;
        step();
        write_en = 1'b0;
        read_en = 1'b0;
        chk("wt_valid", read_valid, 1);
        chk("wt_data", read_data, 8'h01);
        chk("wt_count", count, 4);
        chk("wt_ovf", overflow, 0);
        pop_chk("wt_02", 8'h02);
        pop_chk("wt_03", 8'h03);
        pop_chk("wt_04", 8'h04);
        pop_chk("wt_55", 8'h55);
        chk("wt_empty", fifo_empty, 1);

        push(8'h60);
        for (int i = 1; i < 10; i++) begin
            write_en = 1'b1;
            write_data = 8'(8'h60 + i);
            read_en = 1'b1;
            step();
            chk("wrap_valid", read_valid, 1);
            chk("wrap_data", read_data, 8'(8'h60 + i - 1));
            chk("wrap_count", count, 1);
        end
        write_en = 1'b0;
        pop_chk("wrap_last", 8'h69);
        chk("wrap_empty", fifo_empty, 1);

        read_en = 1'b1;
        step();
        read_en = 1'b0;
        push(8'h81);
        push(8'h82);
        push(8'h83);
        chk("fl_count3", count, 3);
        flush = 1'b1;
        read_en = 1'b1;
        step();
        flush = 1'b0;
        read_en = 1'b0;
        chk("fl_valid", read_valid, 0);
        chk("fl_count", count, 0);
        chk("fl_empty", fifo_empty, 1);
        chk("fl_hold", read_data, 8'h69);
        chk("fl_unf_kept", underflow, 1);
        err_clr = 1'b1;
        read_en = 1'b1;
        step();
        err_clr = 1'b0;
        read_en = 1'b0;
        chk("clr_set_wins", underflow, 1);
        clear_err();
        chk("clr2_unf", underflow, 0);
        chk("clr2_ovf", overflow, 0);

        push(8'h71);
        push(8'h72);
        pop_chk("ar_pre", 8'h71);
        read_en = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        chk("ar_count", count, 0);
        chk("ar_empty", fifo_empty, 1);
        chk("ar_valid", read_valid, 0);
        chk("ar_data", read_data, 0);
        chk("ar_unf", underflow, 0);
        chk("ar_vacant", fifo_vacant, 1);
        read_en = 1'b0;
        step();
        rst = 1'b0;
        step();
        chk("ar_post_empty", fifo_empty, 1);
        chk("ar_post_unf", underflow, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
